serial_adder_seq: RTL and testbench
===================================

SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand set presented.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  addend A.
REQ-007 SHALL have port: b  input  WIDTH  addend B.
REQ-008 SHALL have port: cin  input  1  carry-in.
REQ-009 SHALL have port (SERIAL_ADDER_SUB_EN only): sub  input  1  subtract request.
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  consumer takes result.
REQ-012 SHALL have port: sum  output  WIDTH  result.
REQ-013 SHALL have port: cout  output  1  carry-out of bit WIDTH-1.

Function
REQ-014 SHALL implement FSM with states IDLE, RUN, DONE; in_ready=1 only in IDLE with rst_n high; out_valid=1 only in DONE.
REQ-015 SHALL accept on edge where in_valid&&in_ready: latch a, b into shift registers, carry flop <= cin, bit counter <= 0, IDLE->RUN.
REQ-016 SHALL in each RUN cycle add LSBs: s = a0^b0^c, c_next = majority(a0,b0,c); shift a, b right by one; shift s into MSB of result register; counter +1.
REQ-017 SHALL transition RUN->DONE on edge where counter == WIDTH-1 (i.e. after exactly WIDTH bit-cycles); out_valid rises WIDTH cycles after accept edge.
REQ-018 SHALL present sum = result register and cout = carry flop in DONE; both held stable while out_valid && !out_ready.
REQ-019 SHALL transition DONE->IDLE on edge where out_valid&&out_ready; sum/cout keep last value until next DONE.
REQ-020 SHALL ignore in_valid in RUN and DONE (no overlap, no queueing); a, b, cin sampled only on accept edge.
REQ-021 SHALL give throughput of one operation per WIDTH+2 cycles with in_valid and out_ready held high.
REQ-022 SHALL size counter ceil(log2(WIDTH)), minimum 1 bit; WIDTH=1 completes RUN in one cycle.
REQ-023 SHALL produce result equal to (a + b + cin) mod 2^WIDTH with cout = bit WIDTH of full sum.

Reset
REQ-024 SHALL on rising edge with rst_n low: state<=IDLE, out_valid 0, sum 0, cout 0, counter 0, shift registers 0.
REQ-025 SHALL hold in_ready 0 while rst_n low; in_ready 1 on first cycle after release.
REQ-026 SHALL abandon any in-flight RUN/DONE operation on reset without emitting out_valid.

Configuration
REQ-027 SHALL gate subtraction with macro SERIAL_ADDER_SUB_EN.
REQ-028 SHALL, when defined: on accept with sub=1 latch ~b and force carry flop to 1 (cin ignored), giving a-b mod 2^WIDTH, cout=1 meaning no borrow; sub=0 behaves as REQ-015.
REQ-029 SHALL, when undefined: omit sub port and inversion logic; addition only.

Verification
REQ-030 SHALL cover: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, out_valid exactly 32 cycles after accept edge.
REQ-031 SHALL cover: a=0x12345678, b=0x9ABCDEF0, cin=1 -> sum=0xACF13569, cout=0.
REQ-032 SHALL cover: out_ready low 10 cycles in DONE, in_valid pulsed with a=1,b=1 -> sum/cout unchanged, in_ready=0, pulse not accepted.
REQ-033 SHALL cover: rst_n low for one edge at RUN bit-cycle 15 -> next cycle out_valid=0, sum=0, cout=0; in_ready=1 after release, no result emitted.
REQ-034 SHALL cover: in_valid and out_ready held 1, 3 operand sets -> accepts spaced 34 cycles apart, results in order.
REQ-035 SHALL cover (SERIAL_ADDER_SUB_EN): a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0; a=7, b=5, sub=1 -> sum=0x00000002, cout=1.

Source files
------------

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: latches A/B/cin, adds one bit per cycle, presents sum/cout.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready, a, b, cin,
//        sub (only with SERIAL_ADDER_SUB_EN), out_valid/out_ready, sum, cout.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds subtraction via sub).
module serial_adder_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] b_ld;
  logic             c_ld;
  logic             s;
  logic             maj;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] acc_next;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: a + ~b + 1
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub ? 1'b1 : cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif

  assign s   = sa[0] ^ sb[0] ^ c;
  assign maj = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);

  // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign wide     = {s, acc};
  assign acc_next = wide[WIDTH:1];

  assign in_ready = rst_n && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      acc       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sa    <= a;
            sb    <= b_ld;
            c     <= c_ld;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= maj;
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= acc_next;
            cout      <= maj;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed self-checking bench for serial_adder_seq (WIDTH=32).
// Covers reset, latency, carry chains, backpressure, mid-run reset, throughput.
module tb_serial_adder_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operand set for a single accept edge.
  task automatic accept(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc);
    @(negedge clk);
    chk("pre_accept_in_ready", 64'(in_ready), 64'd1);
    a = va;
    b = vb;
    cin = vc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consume_out_valid", 64'(out_valid), 64'd0);
    chk("consume_in_ready", 64'(in_ready), 64'd1);
  endtask

  int n;
  int seen;
  logic [W-1:0] held_sum;
  logic held_cout;

  logic [W-1:0] va [3];
  logic [W-1:0] vb [3];
  logic         vc [3];
  logic [W-1:0] es [3];
  logic         ec [3];
  int acc_cyc [3];

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Full carry ripple, latency exactly W
    accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("run_in_ready", 64'(in_ready), 64'd0);
    wait_valid(n);
    chk("latency", 64'(n), 64'd32);
    chk("ripple_sum", 64'(sum), 64'h0);
    chk("ripple_cout", 64'(cout), 64'd1);

    // Backpressure: result held, pulsed in_valid ignored
    held_sum = sum;
    held_cout = cout;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 32'd1;
      b = 32'd1;
      in_valid = (i == 4);
      if (i == 4) chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_sum", 64'(sum), 64'(held_sum));
    chk("bp_cout", 64'(cout), 64'(held_cout));
    consume();
    chk("kept_sum", 64'(sum), 64'h0);
    chk("kept_cout", 64'(cout), 64'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("pulse_not_accepted", 64'(seen), 64'd0);

    // Mixed pattern with carry-in
    accept(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    wait_valid(n);
    chk("mix_latency", 64'(n), 64'd32);
    chk("mix_sum", 64'(sum), 64'hACF1_3569);
    chk("mix_cout", 64'(cout), 64'd0);
    consume();

    // Reset at RUN bit-cycle 15
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_sum", 64'(sum), 64'd0);
    chk("mrst_cout", 64'(cout), 64'd0);
    chk("mrst_in_ready_low", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mrst_no_result", 64'(seen), 64'd0);

    // Back-to-back throughput with handshakes held high
    va[0] = 32'd1;          vb[0] = 32'd2;          vc[0] = 1'b0;
    es[0] = 32'd3;          ec[0] = 1'b0;
    va[1] = 32'h8000_0000;  vb[1] = 32'h8000_0000;  vc[1] = 1'b1;
    es[1] = 32'd1;          ec[1] = 1'b1;
    va[2] = 32'hDEAD_BEEF;  vb[2] = 32'h1111_1111;  vc[2] = 1'b0;
    es[2] = 32'hEFBE_D000;  ec[2] = 1'b0;
    begin
      int cyc;
      int idx;
      int ridx;
      cyc = 0;
      idx = 0;
      ridx = 0;
      out_ready = 1'b1;
      while (ridx < 3 && cyc < 300) begin
        @(negedge clk);
        cyc++;
        if (out_valid) begin
          chk($sformatf("tp_sum%0d", ridx), 64'(sum), 64'(es[ridx]));
          chk($sformatf("tp_cout%0d", ridx), 64'(cout), 64'(ec[ridx]));
          ridx++;
        end
        if (in_ready) begin
          if (idx < 3) begin
            a = va[idx];
            b = vb[idx];
            cin = vc[idx];
            in_valid = 1'b1;
            acc_cyc[idx] = cyc;
            idx++;
          end else begin
            in_valid = 1'b0;
          end
        end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("tp_results", 64'(ridx), 64'd3);
      if (idx == 3) begin
        chk("tp_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd34);
        chk("tp_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd34);
      end else begin
        chk("tp_accepts", 64'(idx), 64'd3);
      end
    end

`ifdef SERIAL_ADDER_SUB_EN
    @(negedge clk);
    sub = 1'b1;
    accept(32'd5, 32'd7, 1'b0);
    wait_valid(n);
    chk("sub_neg_sum", 64'(sum), 64'hFFFF_FFFE);
    chk("sub_neg_cout", 64'(cout), 64'd0);
    consume();
    accept(32'd7, 32'd5, 1'b0);
    wait_valid(n);
    chk("sub_pos_sum", 64'(sum), 64'd2);
    chk("sub_pos_cout", 64'(cout), 64'd1);
    consume();
    sub = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
